// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: ALU op codes,
// opcodes, FSM states and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] A_RS1    = 2'd0;
    localparam logic [1:0] A_OLD_PC = 2'd1;
    localparam logic [1:0] A_ZERO   = 2'd2;

    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    // Immediate layout implied by the opcode; formats without an immediate fall back to I.
    function automatic logic [2:0] imm_format(input logic [6:0] opcode);
        case (opcode)
            OPC_STORE:            return IMM_S;
            OPC_BRANCH:           return IMM_B;
            OPC_LUI, OPC_AUIPC:   return IMM_U;
            OPC_JAL:              return IMM_J;
            default:              return IMM_I;
        endcase
    endfunction

    // funct3 to ALU op for OP/OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] alu_base_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational mapping of opcode/funct3/funct7 to the ALU operation used in
// EXECUTE, plus a flag for encodings that must trap at decode time.
module alu_op_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_sel,
    output logic       illegal
);

    logic f7_zero;
    logic f7_alt;
    logic f3_alt_ok;

    assign f7_zero   = (funct7 == 7'h00);
    assign f7_alt    = (funct7 == 7'h20);
    assign f3_alt_ok = (funct3 == 3'd0) || (funct3 == 3'd5);

    always_comb begin
        alu_sel = ALU_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_sel = alu_base_op(funct3, f7_alt);
                illegal = !(f7_zero || (f7_alt && f3_alt_ok));
            end
            OPC_OP_IMM: begin
                // Only the shift forms carry a funct7; elsewhere those bits are immediate.
                alu_sel = alu_base_op(funct3, (funct3 == 3'd5) && f7_alt);
                if (funct3 == 3'd1)
                    illegal = !f7_zero;
                else if (funct3 == 3'd5)
                    illegal = !(f7_zero || f7_alt);
            end
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JALR: begin
                alu_sel = ALU_ADD;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'd0, 3'd1: alu_sel = ALU_SUB;
                    3'd4, 3'd5: alu_sel = ALU_SLT;
                    3'd6, 3'd7: alu_sel = ALU_SLTU;
                    default:    alu_sel = ALU_NONE;
                endcase
            end
            OPC_JAL: begin
                alu_sel = ALU_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM: latches the fetched instruction and drives the
// ALU, operand/PC/writeback muxes and memory/register strobes.
module control_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero_flag,
    output logic [3:0]  alu_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        alu_res_we,
    output logic [2:0]  imm_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        trap
);
    import rv_ctrl_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  dec_alu;
    logic        dec_illegal;
    logic [2:0]  imm_fmt;
    logic        is_load;
    logic        br_taken;
    logic        br_bad;
    logic        unused_ok;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign funct7  = ir[31:25];
    assign imm_fmt = imm_format(opcode);
    assign is_load = (opcode == OPC_LOAD);

    // Register indices feed the datapath directly; XLEN only sizes that datapath.
    assign unused_ok = (^{ir[24:15], ir[11:7]}) ^ (XLEN == 0);

    // SUB-compares (f3[2]=0) take on z for even f3; SLT-compares take on !z for even f3.
    assign br_taken = alu_zero_flag ^ funct3[0] ^ funct3[2];
    assign br_bad   = (funct3[2:1] == 2'b01);

    alu_op_decoder u_alu_op_decoder (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_sel (dec_alu),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_FETCH && mem_ready)
                ir <= instr;
        end
    end

    always_comb begin
        state_nx   = state;
        alu_sel    = ALU_NONE;
        alu_a_sel  = A_RS1;
        alu_b_sel  = B_RS2;
        alu_res_we = 1'b0;
        imm_sel    = IMM_I;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        trap       = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        state_nx = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Branch/jump target old_pc+imm is formed here for later use.
                    alu_sel    = ALU_ADD;
                    alu_a_sel  = A_OLD_PC;
                    alu_b_sel  = B_IMM;
                    alu_res_we = 1'b1;
                    imm_sel    = imm_fmt;
                    state_nx   = dec_illegal ? ST_TRAP : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    alu_sel = dec_alu;
                    imm_sel = imm_fmt;
                    case (opcode)
                        OPC_OP: begin
                            alu_res_we = 1'b1;
                            state_nx   = ST_WRITEBACK;
                        end
                        OPC_OP_IMM, OPC_JALR: begin
                            alu_b_sel  = B_IMM;
                            alu_res_we = 1'b1;
                            state_nx   = ST_WRITEBACK;
                        end
                        OPC_LUI, OPC_AUIPC: begin
                            alu_a_sel  = (opcode == OPC_LUI) ? A_ZERO : A_OLD_PC;
                            alu_b_sel  = B_IMM;
                            alu_res_we = 1'b1;
                            state_nx   = ST_WRITEBACK;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_b_sel  = B_IMM;
                            alu_res_we = 1'b1;
                            state_nx   = ST_MEM;
                        end
                        OPC_JAL: begin
                            pc_we    = 1'b1;
                            pc_sel   = 1'b1;
                            reg_we   = 1'b1;
                            wb_sel   = WB_PC;
                            state_nx = ST_FETCH;
                        end
                        OPC_BRANCH: begin
                            if (br_bad) begin
                                state_nx = ST_TRAP;
                            end else begin
                                pc_we    = br_taken;
                                pc_sel   = br_taken;
                                state_nx = ST_FETCH;
                            end
                        end
                        default: begin
                            state_nx = ST_TRAP;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem_re = is_load;
                    mem_we = !is_load;
                    if (mem_ready)
                        state_nx = is_load ? ST_WRITEBACK : ST_FETCH;
                end
                ST_WRITEBACK: begin
                    reg_we = 1'b1;
                    if (is_load) begin
                        wb_sel = WB_MEM;
                    end else if (opcode == OPC_JALR) begin
                        wb_sel = WB_PC;
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    state_nx = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_nx = ST_FETCH;
                end
            endcase
        end
    end

endmodule
